// File: rtl/min_track_12_bit.sv
// -----------------------------------------------------------------------------
// min_track_12_bit
//
// Streaming windowed-minimum tracker for unsigned sample streams (e.g. ADC
// data). One sample is consumed per valid cycle. After every WIN_LEN accepted
// samples the window minimum and its position (earliest on ties) are reported
// with a one-cycle strobe. Idle cycles (IN_VALID=0) do not break a window.
//
// Ports:
//   CLK       in   1       clock, rising edge
//   RST_N     in   1       asynchronous active-low reset
//   CLR       in   1       synchronous restart, discards the partial window
//                          and wins over a simultaneous IN_VALID
//   IN_VALID  in   1       qualifies IN_DATA (no backpressure)
//   IN_DATA   in   WIDTH   sample
//   OUT_VALID out  1       one-cycle strobe per completed window
//   OUT_MIN   out  WIDTH   minimum of the last completed window (held)
//   OUT_IDX   out  IDX_W   position of that minimum, 0 = first sample (held)
//   BUSY      out  1       registered; high while a window is partially filled
// -----------------------------------------------------------------------------
module min_track_12_bit #(
  parameter int WIDTH   = 12,
  parameter int WIN_LEN = 16,
  parameter int IDX_W   = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLR,
  input  logic             IN_VALID,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  output logic [WIDTH-1:0] OUT_MIN,
  output logic [IDX_W-1:0] OUT_IDX,
  output logic             BUSY
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FILL  = 1'b1;

  localparam logic [IDX_W-1:0] LAST_POS = IDX_W'(WIN_LEN - 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] cnt;
  logic [WIDTH-1:0] run_min;
  logic [IDX_W-1:0] run_idx;

  logic             first_sample;
  logic             last_sample;
  logic             take_new;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    first_sample = 1'b0;
    last_sample  = 1'b0;
    take_new     = 1'b0;
    if (IN_VALID && !CLR) begin
      first_sample = (cnt == '0);
      last_sample  = (cnt == LAST_POS);
      // Strict compare keeps the earliest index among equal minima.
      take_new     = (IN_DATA < run_min);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_EMPTY;
      cnt       <= '0;
      run_min   <= '0;
      run_idx   <= '0;
      OUT_VALID <= 1'b0;
      OUT_MIN   <= '0;
      OUT_IDX   <= '0;
    end else begin
      OUT_VALID <= 1'b0;
      if (CLR) begin
        // The dropped sample does not open a new window; the last report
        // stays visible on OUT_MIN/OUT_IDX.
        state <= ST_EMPTY;
        cnt   <= '0;
      end else if (IN_VALID) begin
        if (first_sample) begin
          run_min <= IN_DATA;
          run_idx <= '0;
          cnt     <= IDX_W'(1);
          state   <= ST_FILL;
        end else if (last_sample) begin
          // Fold the final sample straight into the report so the strobe
          // lands one cycle after it and the next window can start at once.
          OUT_MIN   <= take_new ? IN_DATA : run_min;
          OUT_IDX   <= take_new ? cnt : run_idx;
          OUT_VALID <= 1'b1;
          cnt       <= '0;
          state     <= ST_EMPTY;
        end else begin
          if (take_new) begin
            run_min <= IN_DATA;
            run_idx <= cnt;
          end
          cnt <= cnt + IDX_W'(1);
        end
      end
    end
  end

  assign BUSY = (state == ST_FILL);

endmodule

// File: tb/tb_min_track_12_bit.sv
// -----------------------------------------------------------------------------
// tb_min_track_12_bit
//
// Self-checking bench for min_track_12_bit with WIN_LEN=4, IDX_W=2.
// A window model (queue of accepted samples, minimum found by scanning the
// closed window) predicts the registered outputs; a compare process checks
// all outputs against it on every falling edge. Directed scenarios add
// hand-computed literal expectations, followed by a random regression.
// -----------------------------------------------------------------------------
module tb_min_track_12_bit;

  localparam int WIDTH   = 12;
  localparam int WIN_LEN = 4;
  localparam int IDX_W   = 2;

  logic             CLK;
  logic             RST_N;
  logic             CLR;
  logic             IN_VALID;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic [WIDTH-1:0] OUT_MIN;
  logic [IDX_W-1:0] OUT_IDX;
  logic             BUSY;

  min_track_12_bit #(
    .WIDTH  (WIDTH),
    .WIN_LEN(WIN_LEN),
    .IDX_W  (IDX_W)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .CLR      (CLR),
    .IN_VALID (IN_VALID),
    .IN_DATA  (IN_DATA),
    .OUT_VALID(OUT_VALID),
    .OUT_MIN  (OUT_MIN),
    .OUT_IDX  (OUT_IDX),
    .BUSY     (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: collect accepted samples of the open window; when the
  // window closes, scan it for the smallest value, earliest position first.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] win_q[$];
  logic             m_valid;
  logic [WIDTH-1:0] m_min;
  logic [IDX_W-1:0] m_idx;
  logic             m_busy;
  int               m_strobes = 0;

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      win_q.delete();
      m_valid = 1'b0;
      m_min   = '0;
      m_idx   = '0;
      m_busy  = 1'b0;
    end else begin
      m_valid = 1'b0;
      if (CLR) begin
        win_q.delete();
      end else if (IN_VALID) begin
        win_q.push_back(IN_DATA);
        if (win_q.size() == WIN_LEN) begin
          m_min = win_q[0];
          m_idx = '0;
          for (int i = 1; i < WIN_LEN; i++) begin
            if (win_q[i] < m_min) begin
              m_min = win_q[i];
              m_idx = IDX_W'(i);
            end
          end
          m_valid = 1'b1;
          m_strobes++;
          win_q.delete();
        end
      end
      m_busy = (win_q.size() != 0);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge CLK) begin
    if (cmp_en && RST_N) begin
      check("model_out_valid", 32'(OUT_VALID), 32'(m_valid));
      check("model_out_min",   32'(OUT_MIN),   32'(m_min));
      check("model_out_idx",   32'(OUT_IDX),   32'(m_idx));
      check("model_busy",      32'(BUSY),      32'(m_busy));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic c);
    @(negedge CLK);
    IN_VALID = v;
    IN_DATA  = d;
    CLR      = c;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic expect_out(input string name, input logic vld,
                            input logic [WIDTH-1:0] mn, input logic [IDX_W-1:0] ix);
    check({name, "_valid"}, 32'(OUT_VALID), 32'(vld));
    check({name, "_min"},   32'(OUT_MIN),   32'(mn));
    check({name, "_idx"},   32'(OUT_IDX),   32'(ix));
  endtask

  task automatic send4(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] c, input logic [WIDTH-1:0] d);
    drive(1'b1, a, 1'b0);
    drive(1'b1, b, 1'b0);
    drive(1'b1, c, 1'b0);
    drive(1'b1, d, 1'b0);
  endtask

  logic [WIDTH-1:0] seq8 [8];

  initial begin
    RST_N    = 1'b0;
    CLR      = 1'b0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    repeat (3) @(negedge CLK);
    RST_N  = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    expect_out("reset", 1'b0, 12'd0, 2'd0);
    check("reset_busy", 32'(BUSY), 32'd0);

    // Basic window
    send4(12'd300, 12'd120, 12'd500, 12'd121);
    idle();
    expect_out("basic", 1'b1, 12'd120, 2'd1);
    check("basic_busy_after", 32'(BUSY), 32'd0);
    idle();
    expect_out("basic_hold", 1'b0, 12'd120, 2'd1);

    // Ties and extremes
    send4(12'hFFF, 12'd7, 12'd7, 12'hFFF);
    idle();
    expect_out("tie", 1'b1, 12'd7, 2'd1);
    send4(12'd0, 12'd0, 12'd0, 12'd0);
    idle();
    expect_out("zeros", 1'b1, 12'd0, 2'd0);

    // Back-to-back windows, no bubble
    seq8 = '{12'd9, 12'd8, 12'd7, 12'd6, 12'd1, 12'd2, 12'd3, 12'd4};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq8[i], 1'b0);
      if (i == 4) expect_out("b2b_first", 1'b1, 12'd6, 2'd3);
      if (i == 5) check("b2b_strobe_one_cycle", 32'(OUT_VALID), 32'd0);
    end
    idle();
    expect_out("b2b_second", 1'b1, 12'd1, 2'd0);

    // Same data with idle gaps between samples
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, seq8[i], 1'b0);
      idle();
      if (i == 3) expect_out("gap_first", 1'b1, 12'd6, 2'd3);
      if (i == 7) expect_out("gap_second", 1'b1, 12'd1, 2'd0);
      if (i == 2) check("gap_busy", 32'(BUSY), 32'd1);
      idle();
      if (i == 3) check("gap_strobe_one_cycle", 32'(OUT_VALID), 32'd0);
    end

    // CLR mid-window, simultaneous sample dropped
    drive(1'b1, 12'd50, 1'b0);
    drive(1'b1, 12'd10, 1'b0);
    drive(1'b1, 12'd5,  1'b1);
    drive(1'b1, 12'd40, 1'b0);
    expect_out("clr_hold", 1'b0, 12'd1, 2'd0);
    check("clr_busy", 32'(BUSY), 32'd0);
    drive(1'b1, 12'd30, 1'b0);
    drive(1'b1, 12'd20, 1'b0);
    drive(1'b1, 12'd60, 1'b0);
    expect_out("clr_pre", 1'b0, 12'd1, 2'd0);
    idle();
    expect_out("clr_result", 1'b1, 12'd20, 2'd2);

    // Asynchronous reset mid-window
    drive(1'b1, 12'd100, 1'b0);
    drive(1'b1, 12'd101, 1'b0);
    idle();
    check("pre_rst_busy", 32'(BUSY), 32'd1);
    #1 RST_N = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 12'd0, 2'd0);
    check("async_rst_busy", 32'(BUSY), 32'd0);
    #1 RST_N = 1'b1;
    send4(12'd3, 12'd2, 12'd1, 12'd4);
    idle();
    expect_out("post_rst", 1'b1, 12'd1, 2'd2);

    // Random regression against the model
    for (int blk = 0; blk < 10; blk++) begin
      int density;
      density = $urandom_range(10, 100);
      for (int i = 0; i < 1000; i++) begin
        logic             v;
        logic             c;
        logic [WIDTH-1:0] d;
        v = ($urandom_range(1, 100) <= density);
        c = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 3) == 0) d = WIDTH'($urandom_range(0, 3));
        else                           d = WIDTH'($urandom_range(0, 4095));
        drive(v, d, c);
      end
    end
    idle();
    idle();
    check("random_strobes_seen", 32'(m_strobes > 100), 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/min_track_12_bit.md
# min_track_12_bit

Streaming windowed-minimum tracker for 12-bit unsigned sample streams, such as ADC data. It is the trough-side counterpart of the toolbox's registered 12-bit maximum selector. It consumes one sample per valid cycle and, after every WIN_LEN accepted samples, reports the window minimum and its position with a one-cycle strobe. It sits in the TOOLBOX between the sample source and downstream threshold or peak logic.

## Interface
Parameters:
- WIDTH, 12: sample width. The comparison is unsigned.
- WIN_LEN, 16: samples per window. Legal range is 2..65535.
- IDX_W, 4: index width, equal to ceil(log2(WIN_LEN)). It must satisfy 2**IDX_W >= WIN_LEN.

Ports:
- CLK  in  1  the single clock; all state changes on its rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- CLR  in  1  synchronous restart. It discards the partial window.
- IN_VALID  in  1  qualifies IN_DATA. There is no backpressure; every valid cycle is accepted.
- IN_DATA  in  WIDTH  sample.
- OUT_VALID  out  1  one-cycle strobe marking a completed window.
- OUT_MIN  out  WIDTH  minimum of the last completed window. Held between strobes.
- OUT_IDX  out  IDX_W  position of that minimum within its window (0 = first sample). Held between strobes.
- BUSY  out  1  high while a window is partially filled.

## Operation
- Internal state:
  - cnt: 0..WIN_LEN-1, the position of the next sample.
  - run_min: running minimum, WIDTH bits.
  - run_idx: position of run_min, IDX_W bits.
- State machine:
  - EMPTY: cnt=0 and BUSY=0.
  - FILL: 0<cnt<WIN_LEN and BUSY=1.
  - Transitions:
    - EMPTY->FILL on an accepted sample.
    - FILL->FILL while cnt<WIN_LEN-1.
    - FILL->EMPTY on the last sample or on CLR.
- Accepted sample with cnt=0:
  - run_min<=IN_DATA, run_idx<=0, cnt<=1.
- Accepted sample with 0<cnt<WIN_LEN-1:
  - If IN_DATA < run_min (strict), then run_min<=IN_DATA and run_idx<=cnt.
  - cnt<=cnt+1.
- Accepted sample with cnt=WIN_LEN-1:
  - Final value = IN_DATA if IN_DATA < run_min, else run_min. The index is chosen the same way.
  - The final value and index are registered into OUT_MIN/OUT_IDX.
  - OUT_VALID<=1 and cnt<=0.
- Ties: the strict compare keeps the earliest index of equal minima.
- Gaps: IN_VALID=0 leaves all state unchanged, and OUT_VALID<=0. Windows span any number of idle cycles.
- CLR=1:
  - cnt<=0 and OUT_VALID<=0. run_min and run_idx are don't-care.
  - OUT_MIN/OUT_IDX keep their last reported values.
  - CLR has priority over a simultaneous IN_VALID; that sample is dropped and does not start a new window.
- CLR in EMPTY has no effect beyond forcing OUT_VALID<=0.

## Timing
- Reset values (asynchronous, while RST_N=0): OUT_VALID=0, OUT_MIN=0, OUT_IDX=0, BUSY=0, cnt=0, run_min=0, run_idx=0.
- Latency: OUT_VALID is high in exactly the cycle after the edge that accepted sample WIN_LEN-1, and OUT_MIN/OUT_IDX are valid in that same cycle.
- OUT_VALID is high for exactly one cycle per completed window.
- Back-to-back windows: the first sample of window n+1 may be accepted in the same cycle OUT_VALID reports window n. Throughput is one sample per clock with no bubble.
- BUSY is registered. It rises the cycle after the first accepted sample and falls the cycle after the last sample or CLR.
- Reset mid-window: the partial window is lost, and the first valid sample after RST_N deasserts is position 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIN_LEN=4 and IDX_W=2.
- Reset release then 4 valid samples 300, 120, 500, 121 → one cycle after the 4th: OUT_VALID=1, OUT_MIN=120, OUT_IDX=1. The next cycle: OUT_VALID=0, with values held.
- Ties and extremes: 0xFFF, 7, 7, 0xFFF → OUT_MIN=7, OUT_IDX=1. Then all-zero 0, 0, 0, 0 → OUT_MIN=0, OUT_IDX=0.
- Back-to-back plus gaps: 8 continuous samples 9,8,7,6 | 1,2,3,4 → strobes 4 cycles apart, reporting (6,3) then (1,0). Repeating with IN_VALID=0 idle cycles inserted between samples gives identical results, with each strobe one cycle after the 4th valid sample.
- CLR mid-window: samples 50, 10, then CLR with IN_VALID=1 and data 5, then 40, 30, 20, 60 → a single strobe with OUT_MIN=20, OUT_IDX=2. The sample 5 is dropped. The earlier OUT_MIN/OUT_IDX are held until that strobe.
- Async reset mid-window: after 2 samples, pulse RST_N low between clock edges → all outputs are 0 immediately. The next 4 samples 3, 2, 1, 4 yield OUT_MIN=1, OUT_IDX=2.
- Random regression: 10k random samples with random IN_VALID density and occasional CLR → compared against a reference model of minimum and earliest index per window, plus the BUSY/OUT_VALID timing rules.
